// File: rtl/enc_gray_codec_pkg.sv
// Shared types and segment arithmetic for the pipelined binary/Gray codec.
// Used by all codec files; the optional parity output is ENC_GRAY_CODEC_PARITY_EN.
package enc_gray_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } gray_mode_e;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 32'sd1) / stages;
    endfunction

    // Stage k is 1-based; an empty segment yields hi < lo.
    function automatic int seg_hi(input int width, input int stages, input int k);
        return width - 32'sd1 - (k - 32'sd1) * seg_width(width, stages);
    endfunction

    function automatic int seg_lo(input int width, input int stages, input int k);
        int lo;
        lo = width - k * seg_width(width, stages);
        return (lo < 32'sd0) ? 32'sd0 : lo;
    endfunction

endpackage

// File: rtl/enc_gray_codec_if.sv
// Valid/ready bus of the binary/Gray codec: input word side and result side.
// out_parity exists only when ENC_GRAY_CODEC_PARITY_EN is defined.
interface enc_gray_codec_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
`ifdef ENC_GRAY_CODEC_PARITY_EN
    logic             out_parity;
`endif

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
`ifdef ENC_GRAY_CODEC_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
`ifdef ENC_GRAY_CODEC_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/enc_gray_codec_stage.sv
// One pipeline stage: resolves bits [HI:LO] of a Gray-to-binary word, or the
// whole binary-to-Gray word when FIRST. Parity (ENC_GRAY_CODEC_PARITY_EN) is held by LAST.
module enc_gray_stage
    import enc_gray_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int HI    = 9,
    parameter int LO    = 5,
    parameter bit FIRST = 1'b1
`ifdef ENC_GRAY_CODEC_PARITY_EN
    , parameter bit LAST = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  gray_mode_e       prev_mode,
    input  logic             next_advance,
    output logic             advance,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output gray_mode_e       mode
`ifdef ENC_GRAY_CODEC_PARITY_EN
    , input  logic           parity_in
    , output logic           parity
`endif
);
    localparam bit EMPTY    = (HI < LO);
    // The previous stage has already turned bit HI+1 into its binary value.
    localparam int SEED_IDX = (FIRST || EMPTY) ? 32'sd0 : HI + 32'sd1;

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    gray_mode_e       mode_r;
    logic [WIDTH-1:0] data_next_s;
    logic             carry_s;

    assign advance = ~valid_r | next_advance;
    assign valid   = valid_r;
    assign data    = data_r;
    assign mode    = mode_r;

    // Convert the incoming word as far as this stage is responsible for.
    always_comb begin
        data_next_s = prev_data;
        carry_s     = 1'b0;
        if (prev_mode == MODE_B2G) begin
            if (FIRST) begin
                data_next_s = prev_data ^ {1'b0, prev_data[WIDTH-1:1]};
            end else begin
                data_next_s = prev_data;
            end
        end else begin
            carry_s = FIRST ? 1'b0 : prev_data[SEED_IDX];
            for (int i = HI; i >= LO; i--) begin
                carry_s        = carry_s ^ prev_data[i];
                data_next_s[i] = carry_s;
            end
        end
    end

    // Stage register: loads whenever the stage advances and a word is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            mode_r  <= MODE_B2G;
        end else if (advance) begin
            valid_r <= prev_valid;
            if (prev_valid) begin
                data_r <= data_next_s;
                mode_r <= prev_mode;
            end
        end
    end

`ifdef ENC_GRAY_CODEC_PARITY_EN
    if (LAST) begin : g_parity
        logic parity_r;

        // Parity of the final word, loaded together with data_r.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                parity_r <= 1'b0;
            end else if (advance && prev_valid) begin
                parity_r <= parity_in ^ (^data_next_s);
            end
        end
        assign parity = parity_r;
    end else begin : g_parity_thru
        assign parity = parity_in;
    end
`endif

endmodule

// File: rtl/enc_gray_codec.sv
// Pipelined binary/Gray converter with valid/ready on both sides and per-word mode.
// Optional out_parity port: define ENC_GRAY_CODEC_PARITY_EN.
module enc_gray_codec
    import enc_gray_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    enc_gray_codec_if.slave bus
);
    if (WIDTH < 32'sd2 || WIDTH > 32'sd64 || STAGES < 32'sd1 || STAGES > WIDTH) begin : g_bad_cfg
        $error("enc_gray_codec: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] adv_s;
    logic [WIDTH-1:0]  data_s [STAGES];
    gray_mode_e        mode_s [STAGES];
`ifdef ENC_GRAY_CODEC_PARITY_EN
    logic [STAGES:0]   par_s;
    assign par_s[0]       = 1'b0;
    assign bus.out_parity = par_s[STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             pv_s;
        logic [WIDTH-1:0] pd_s;
        gray_mode_e       pm_s;
        logic             na_s;

        if (k == 0) begin : g_head
            assign pv_s = bus.in_valid;
            assign pd_s = bus.in_data;
            assign pm_s = gray_mode_e'(bus.in_mode);
        end else begin : g_body
            assign pv_s = valid_s[k-1];
            assign pd_s = data_s[k-1];
            assign pm_s = mode_s[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign na_s = bus.out_ready;
        end else begin : g_link
            assign na_s = adv_s[k+1];
        end

        enc_gray_stage #(
            .WIDTH (WIDTH),
            .HI    (seg_hi(WIDTH, STAGES, k + 1)),
            .LO    (seg_lo(WIDTH, STAGES, k + 1)),
            .FIRST (k == 0)
`ifdef ENC_GRAY_CODEC_PARITY_EN
            , .LAST (k == STAGES - 1)
`endif
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .prev_valid   (pv_s),
            .prev_data    (pd_s),
            .prev_mode    (pm_s),
            .next_advance (na_s),
            .advance      (adv_s[k]),
            .valid        (valid_s[k]),
            .data         (data_s[k]),
            .mode         (mode_s[k])
`ifdef ENC_GRAY_CODEC_PARITY_EN
            , .parity_in  (par_s[k])
            , .parity     (par_s[k+1])
`endif
        );
    end

    // Gating with rst_n keeps the input closed for the whole reset pulse.
    assign bus.in_ready  = adv_s[0] & rst_n;
    assign bus.out_valid = valid_s[STAGES-1];
    assign bus.out_data  = data_s[STAGES-1];
    assign bus.out_mode  = mode_s[STAGES-1];

endmodule

// File: tb/tb_enc_gray_codec.sv
// Self-checking bench for enc_gray_codec: directed table on 10/2, then random
// traffic on 10/2, 7/1, 7/7 and 64/5 against a reference model.
module tb_enc_gray_codec;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    enc_gray_codec_if #(.WIDTH(10)) if0 ();
    enc_gray_codec_if #(.WIDTH(7))  if1 ();
    enc_gray_codec_if #(.WIDTH(7))  if2 ();
    enc_gray_codec_if #(.WIDTH(64)) if3 ();

    enc_gray_codec #(.WIDTH(10), .STAGES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    enc_gray_codec #(.WIDTH(7),  .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    enc_gray_codec #(.WIDTH(7),  .STAGES(7)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    enc_gray_codec #(.WIDTH(64), .STAGES(5)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic        drv_valid [4];
    logic [63:0] drv_data  [4];
    logic        drv_mode  [4];
    logic        drv_oready[4];
    logic        mon_ready [4];
    logic        mon_valid [4];
    logic [63:0] mon_data  [4];
    logic        mon_mode  [4];

    assign if0.in_valid = drv_valid[0]; assign if0.in_data = drv_data[0][9:0];
    assign if0.in_mode  = drv_mode[0];  assign if0.out_ready = drv_oready[0];
    assign if1.in_valid = drv_valid[1]; assign if1.in_data = drv_data[1][6:0];
    assign if1.in_mode  = drv_mode[1];  assign if1.out_ready = drv_oready[1];
    assign if2.in_valid = drv_valid[2]; assign if2.in_data = drv_data[2][6:0];
    assign if2.in_mode  = drv_mode[2];  assign if2.out_ready = drv_oready[2];
    assign if3.in_valid = drv_valid[3]; assign if3.in_data = drv_data[3];
    assign if3.in_mode  = drv_mode[3];  assign if3.out_ready = drv_oready[3];

    assign mon_ready[0] = if0.in_ready; assign mon_valid[0] = if0.out_valid;
    assign mon_data[0]  = 64'(if0.out_data); assign mon_mode[0] = if0.out_mode;
    assign mon_ready[1] = if1.in_ready; assign mon_valid[1] = if1.out_valid;
    assign mon_data[1]  = 64'(if1.out_data); assign mon_mode[1] = if1.out_mode;
    assign mon_ready[2] = if2.in_ready; assign mon_valid[2] = if2.out_valid;
    assign mon_data[2]  = 64'(if2.out_data); assign mon_mode[2] = if2.out_mode;
    assign mon_ready[3] = if3.in_ready; assign mon_valid[3] = if3.out_valid;
    assign mon_data[3]  = if3.out_data; assign mon_mode[3] = if3.out_mode;
`ifdef ENC_GRAY_CODEC_PARITY_EN
    logic mon_par[4];
    assign mon_par[0] = if0.out_parity; assign mon_par[1] = if1.out_parity;
    assign mon_par[2] = if2.out_parity; assign mon_par[3] = if3.out_parity;
`endif

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_w(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] b2g(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    // bin[i] is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [63:0] g2b(input logic [63:0] g, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- DUT0 cycle helper ----------------
    logic        s_ready, s_valid, s_mode, s_par;
    logic [63:0] s_data;
    logic [64:0] recv_q[$];

    task automatic cyc();
        @(negedge clk);
        s_ready = mon_ready[0];
        s_valid = mon_valid[0];
        s_data  = mon_data[0];
        s_mode  = mon_mode[0];
`ifdef ENC_GRAY_CODEC_PARITY_EN
        s_par   = mon_par[0];
`else
        s_par   = 1'b0;
`endif
        if (s_valid && drv_oready[0]) recv_q.push_back({s_mode, s_data});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic [9:0] din;
        logic [9:0] dout;
        logic       par;
    } vec_t;

    typedef struct {
        int          d;
        logic [63:0] data;
        logic        mode;
    } sb_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        sb_t         sb_q[$];
        int          wd[4];
        int          lat, stalls, seen, idx;
        logic        got;
        logic [63:0] v, held;
        logic        prev_hold[4];
        logic [63:0] prev_data[4];
        logic        prev_mode[4];

        wd = '{10, 7, 7, 64};
        tbl[0] = '{1'b0, 10'h3FF, 10'h200, 1'b1};
        tbl[1] = '{1'b1, 10'h3FF, 10'h2AA, 1'b1};
        tbl[2] = '{1'b1, 10'h200, 10'h3FF, 1'b0};
        tbl[3] = '{1'b0, 10'h000, 10'h000, 1'b0};
        tbl[4] = '{1'b0, 10'h2AA, 10'h3FF, 1'b0};
        tbl[5] = '{1'b1, 10'h155, 10'h199, 1'b1};
        tbl[6] = '{1'b0, 10'h100, 10'h180, 1'b0};
        tbl[7] = '{1'b1, 10'h001, 10'h001, 1'b1};
        tbl[8] = '{1'b0, 10'h001, 10'h001, 1'b1};

        for (int d = 0; d < 4; d++) begin
            drv_valid[d] = 1'b0; drv_data[d] = '0; drv_mode[d] = 1'b0; drv_oready[d] = 1'b1;
            prev_hold[d] = 1'b0; prev_data[d] = '0; prev_mode[d] = 1'b0;
        end
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk("reset_in_ready", 64'(mon_ready[d]), 64'd0);
        chk("reset_out_valid", 64'(mon_valid[0]), 64'd0);
        chk("reset_out_data", mon_data[0], 64'd0);
        chk("reset_out_mode", 64'(mon_mode[0]), 64'd0);
`ifdef ENC_GRAY_CODEC_PARITY_EN
        chk("reset_out_parity", 64'(mon_par[0]), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();
        chk("release_in_ready", 64'(s_ready), 64'd1);

        // Directed vectors, one word at a time
        for (int t = 0; t < 9; t++) begin
            recv_q.delete();
            drv_valid[0] = 1'b1; drv_data[0] = 64'(tbl[t].din); drv_mode[0] = tbl[t].mode;
            cyc();
            chk("tbl_in_ready", 64'(s_ready), 64'd1);
            drv_valid[0] = 1'b0;
            lat = 0; got = 1'b0;
            while (!got && lat < 10) begin
                cyc();
                lat++;
                if (s_valid) got = 1'b1;
            end
            chk("tbl_latency", 64'(lat), 64'd2);
            chk("tbl_data", s_data, 64'(tbl[t].dout));
            chk("tbl_mode", 64'(s_mode), 64'(tbl[t].mode));
`ifdef ENC_GRAY_CODEC_PARITY_EN
            chk("tbl_parity", 64'(s_par), 64'(tbl[t].par));
`endif
            chk("tbl_count", 64'(recv_q.size()), 64'd1);
        end

        // All 1024 values, encode then decode, back to back
        recv_q.delete(); stalls = 0;
        for (int c = 0; c < 2052; c++) begin
            if (c < 2048) begin
                v = 64'(c / 2);
                drv_valid[0] = 1'b1;
                drv_mode[0]  = (c % 2) == 1;
                drv_data[0]  = drv_mode[0] ? b2g(v) : v;
            end else begin
                drv_valid[0] = 1'b0;
            end
            cyc();
            if (c < 2048 && !s_ready) stalls++;
        end
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_count", 64'(recv_q.size()), 64'd2048);
        for (int j = 0; j < 2048 && j < recv_q.size(); j++) begin
            v = 64'(j / 2);
            chk("stream_word", 65'(recv_q[j]), (j % 2 == 1) ? {1'b1, v} : {1'b0, b2g(v)});
        end

        // Backpressure with a full pipeline
        recv_q.delete(); drv_oready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_mode[0] = 1'b0; drv_data[0] = 64'h155;
        cyc(); chk("stall_acc_a", 64'(s_ready), 64'd1);
        drv_mode[0] = 1'b1; drv_data[0] = 64'h0F0;
        cyc(); chk("stall_acc_b", 64'(s_ready), 64'd1);
        drv_mode[0] = 1'b0; drv_data[0] = 64'h3C3;
        cyc(); chk("stall_full_ready", 64'(s_ready), 64'd0);
        held = s_data;
        chk("stall_head", held, b2g(64'h155));
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk("stall_in_ready", 64'(s_ready), 64'd0);
            chk("stall_out_valid", 64'(s_valid), 64'd1);
            chk("stall_out_data", s_data, b2g(64'h155));
        end
        drv_oready[0] = 1'b1;
        cyc(); chk("stall_release_ready", 64'(s_ready), 64'd1);
        drv_valid[0] = 1'b0;
        repeat (4) cyc();
        chk("stall_count", 64'(recv_q.size()), 64'd3);
        if (recv_q.size() == 3) begin
            chk("stall_w0", 65'(recv_q[0]), {1'b0, b2g(64'h155)});
            chk("stall_w1", 65'(recv_q[1]), {1'b1, g2b(64'h0F0, 10)});
            chk("stall_w2", 65'(recv_q[2]), {1'b0, b2g(64'h3C3)});
        end

        // Reset with two words in flight
        recv_q.delete(); drv_oready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_mode[0] = 1'b0; drv_data[0] = 64'h2F0;
        cyc();
        drv_data[0] = 64'h10F;
        cyc();
        drv_valid[0] = 1'b0;
        #2;
        chk("pre_reset_valid", 64'(mon_valid[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(mon_valid[0]), 64'd0);
        chk("rst_in_ready", 64'(mon_ready[0]), 64'd0);
        chk("rst_out_data", mon_data[0], 64'd0);
        cyc();
        chk("rst_in_ready_hold", 64'(s_ready), 64'd0);
        rst_n = 1'b1; drv_oready[0] = 1'b1;
        cyc();
        chk("post_rst_in_ready", 64'(s_ready), 64'd1);
        seen = 0;
        for (int r = 0; r < 6; r++) begin
            cyc();
            if (s_valid) seen++;
        end
        chk("post_rst_stale", 64'(seen), 64'd0);

        // Random traffic on all four configurations
        sb_q.delete();
        for (int c = 0; c < 2600; c++) begin
            for (int d = 0; d < 4; d++) begin
                if (c < 2500) begin
                    drv_valid[d]  = $urandom_range(0, 3) != 0;
                    drv_mode[d]   = $urandom_range(0, 1) == 1;
                    drv_data[d]   = {$urandom(), $urandom()} & mask_w(wd[d]);
                    drv_oready[d] = $urandom_range(0, 3) != 0;
                end else begin
                    drv_valid[d]  = 1'b0;
                    drv_oready[d] = 1'b1;
                end
            end
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (prev_hold[d]) begin
                    chk("rnd_hold_valid", 64'(mon_valid[d]), 64'd1);
                    chk("rnd_hold_data", mon_data[d], prev_data[d]);
                    chk("rnd_hold_mode", 64'(mon_mode[d]), 64'(prev_mode[d]));
                end
                if (mon_valid[d] && drv_oready[d]) begin
                    idx = -1;
                    for (int j = 0; j < sb_q.size(); j++)
                        if (idx < 0 && sb_q[j].d == d) idx = j;
                    if (idx < 0) begin
                        chk("rnd_unexpected_word", 64'(d), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("rnd_data", mon_data[d], sb_q[idx].data);
                        chk("rnd_mode", 64'(mon_mode[d]), 64'(sb_q[idx].mode));
`ifdef ENC_GRAY_CODEC_PARITY_EN
                        chk("rnd_parity", 64'(mon_par[d]), 64'(^sb_q[idx].data));
`endif
                        sb_q.delete(idx);
                    end
                end
                if (drv_valid[d] && mon_ready[d]) begin
                    sb_q.push_back('{d, drv_mode[d] ? g2b(drv_data[d], wd[d]) : b2g(drv_data[d]),
                                     drv_mode[d]});
                end
                prev_hold[d] = mon_valid[d] && !drv_oready[d];
                prev_data[d] = mon_data[d];
                prev_mode[d] = mon_mode[d];
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_all_delivered", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/enc_gray_codec.md
# enc_gray_codec

Parametrised, pipelined binary/Gray code converter with per-transfer mode select and valid/ready flow control on both sides. It supersedes the fixed 10-bit combinational binary-to-Gray encoder. It adds Gray-to-binary decode, arbitrary width and a configurable pipeline depth that splits the prefix-XOR chain across stages. It sits between counter/pointer producers and CDC or position-decode consumers in the encoder subsystem.

## Interface
- WIDTH, 10, code width in bits; legal range 2..64
- STAGES, 2, pipeline depth; legal range 1..WIDTH; elaboration error outside range
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  binary (mode 0) or Gray (mode 1) word
- in_mode  in  1  0 = bin-to-Gray, 1 = Gray-to-bin; sampled with in_data
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  converted word
- out_mode  out  1  mode the word was converted under
- out_parity  out  1  only with ENC_GRAY_CODEC_PARITY_EN

## Operation
- Transfer on either side occurs when valid & ready are both high at a rising clk edge.
- Each stage k (1..STAGES) holds a valid bit, a data register, a mode bit and a carry bit.
- Segment size SEG = ceil(WIDTH/STAGES).
- Stage k resolves bits [WIDTH-1-(k-1)*SEG : max(0, WIDTH-k*SEG)]. A stage whose segment is empty passes data through unchanged.
- Mode 0, bin-to-Gray:
  - All bits are resolved in stage 1: gray[i] = bin[i+1] ^ bin[i], and gray[WIDTH-1] = bin[WIDTH-1].
  - Later stages only register the word.
- Mode 1, Gray-to-bin:
  - bin[i] = XOR of gray[WIDTH-1:i].
  - Stage k resolves its segment MSB-first, seeded by carry = the resolved LSB of the previous segment. Stage 1 uses carry = 0.
  - Bits below the segment pass through unresolved to the next stage.
- Mixed modes in flight are legal; each word carries its own mode bit.
- Stage k advances when it is not valid, or when the next stage advances. The last stage advances when out_ready is high.
- in_ready = advance condition of stage 1, combinational from out_ready through the valid chain.
- While the last stage is valid and out_ready is low, out_data, out_mode and out_valid hold stable.
- No data loss or duplication under any valid/ready pattern.

## Timing
- Latency: STAGES cycles from input acceptance to out_valid, with no stall.
- Throughput: one word per cycle while out_ready is high.
- Outputs out_valid, out_data, out_mode and out_parity are registered.
- Reset values:
  - all stage valid bits 0
  - out_valid 0, out_data 0, out_mode 0, out_parity 0
  - in_ready 0 while rst_n is low; in_ready 1 in the first cycle after release
- Reset asserted mid-operation discards all in-flight words immediately. No partial output appears after release.
- Simultaneous accept and emit with the pipeline full: legal, in_ready stays 1, full throughput.
- out_ready low with the pipeline full: in_ready goes low in the same cycle.
- STAGES = 1: purely a registered converter; full prefix XOR in one cycle.
- STAGES = WIDTH: one bit per stage.

## Configuration
- Macro: ENC_GRAY_CODEC_PARITY_EN.
- Defined:
  - out_parity port exists; it is the registered XOR of out_data, computed in the last stage and aligned with out_data.
  - Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package enc_gray_pkg holds:
  - typedef gray_mode_e (MODE_B2G = 1'b0, MODE_G2B = 1'b1)
  - function seg_width(WIDTH, STAGES) returning ceil(WIDTH/STAGES)
  - function seg_lo(WIDTH, STAGES, k)
- Sub-module enc_gray_stage, one instance per stage:
  - parameters WIDTH, HI, LO (segment bounds), FIRST (stage 1 applies bin-to-Gray)
  - contains the stage register, valid bit and local advance logic
- enc_gray_codec instantiates the stage sub-module with generate and wires the ready chain.

## Test plan
- WIDTH=10, STAGES=2: mode 0, in_data 10'h3FF -> out_data 10'h200, out_mode 0, two cycles after accept.
- Mode 1 decodes:
  - in_data 10'h3FF -> 10'h2AA
  - in_data 10'h200 -> 10'h3FF
  - with PARITY_EN, out_parity = 1 for 10'h2AA
- Back-to-back alternating modes, 1024 words (all 10-bit values, each encoded then decoded) -> decode of the encode equals the original; one word per cycle.
- out_ready held low 3 cycles with the pipeline full -> in_ready low, out_data stable, no word dropped or duplicated after release.
- rst_n pulsed low with 2 words in flight -> out_valid 0 immediately, in_ready 0 during reset, no stale output after release.
- Corner configurations, random stimulus, checked against a reference model:
  - WIDTH=7, STAGES=1
  - WIDTH=7, STAGES=7
  - WIDTH=64, STAGES=5 (uneven segments)
